// File: rtl/divider_4bit_if.sv
// Request/response bundle for the 4-bit restoring divider.
// The master issues operands and start; the slave returns quotient, remainder and status.
interface divider_4bit_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dz;

    modport master (
        output start, a, b,
        input  q, r, busy, done, dz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, dz
    );
endinterface

// File: rtl/divider_4bit.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero completes in one cycle with dz set.
module divider_4bit (
    input  logic          clk,
    input  logic          rst_n,
    divider_4bit_if.slave bus
);

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a_lat;
    logic [W-1:0]   r_b_lat;
    logic [W:0]     r_rem;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_busy;
    logic           r_done;
    logic           r_dz;

    logic [W:0]     w_shift;
    logic [W+1:0]   w_sum;
    logic           w_no_borrow;
    logic [W:0]     w_next_rem;
    logic           w_unused;

    // Trial subtraction as rem + ~{0,b} + 1; the carry out means no borrow.
    assign w_shift     = {r_rem[W-1:0], r_a_lat[r_cnt]};
    assign w_sum       = {1'b0, w_shift} + {1'b0, ~{1'b0, r_b_lat}} + (W+2)'(1);
    assign w_no_borrow = w_sum[W+1];
    assign w_next_rem  = w_no_borrow ? w_sum[W:0] : w_shift;

    // Restored remainder is always below the divisor, so its top bit is never consulted.
    assign w_unused    = r_rem[W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_lat <= '0;
            r_b_lat <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.b != W'(0)) begin
                            r_a_lat <= bus.a;
                            r_b_lat <= bus.b;
                            r_rem   <= '0;
                            r_q     <= '0;
                            r_cnt   <= CW'(W - 1);
                            r_dz    <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end else begin
                            r_q     <= '1;
                            r_r     <= bus.a;
                            r_dz    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_CALC: begin
                    r_rem        <= w_next_rem;
                    r_q[r_cnt]   <= w_no_borrow;
                    if (r_cnt == CW'(0)) begin
                        r_r     <= w_next_rem[W-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;

endmodule

// File: doc/divider_4bit.md
# divider_4bit

Sequential 4-bit unsigned restoring divider for the ALU datapath. It is the inverse arithmetic companion to `adder_4bit`: it computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock, with a start/busy/done handshake. The ALU control issues one division at a time and reads the results when `done` pulses.

## Interface
Parameters:
- none; operand width is fixed at 4 bits to match `adder_4bit`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous reset, active-low, sampled on the rising edge of `clk`.
- `start`  input  1  request a division; accepted only in IDLE or DONE.
- `a`  input  4  dividend, unsigned; sampled in the cycle `start` is accepted.
- `b`  input  4  divisor, unsigned; sampled in the cycle `start` is accepted.
- `q`  output  4  quotient, registered.
- `r`  output  4  remainder, registered.
- `busy`  output  1  high while iterating (CALC).
- `done`  output  1  one-cycle pulse; `q`, `r` and `dz` are valid from this cycle onward.
- `dz`  output  1  divide-by-zero flag for the last accepted operation.

## Operation
- Reset (`rst_n`=0 at an edge): state = IDLE; `q`=0, `r`=0, `busy`=0, `done`=0, `dz`=0; iteration counter = 0; any in-flight operation is aborted with no `done`.
- States:
  - IDLE: `start`=1 and `b`!=0 → latch `a` and `b`, clear partial remainder (5-bit) and quotient, counter=3, go to CALC. `start`=1 and `b`=0 → go to DONE with `q`=4'b1111, `r`=`a`, `dz`=1.
  - CALC: each cycle, `rem` = {`rem`[3:0], `a_lat`[counter]}. Trial subtraction `rem` − {0,`b_lat`} is computed as `rem` + ~`b_lat` + 1, and carry-out = no borrow. If no borrow, `rem` takes the difference and `q`[counter]=1; otherwise `rem` is unchanged and `q`[counter]=0. At counter=0, go to DONE; otherwise decrement.
  - DONE: `done`=1, `r`=`rem`[3:0], `dz`=0 for valid divisors. The next state is IDLE, unless `start`=1, which is accepted exactly as in IDLE.
- `start` in CALC is ignored; it is not queued.
- `q`, `r` and `dz` hold their values from `done` until the next accepted `start`. On acceptance, `dz` clears and `q`/`r` may change during CALC; they are valid only from `done`.
- Every result satisfies `a` = `q`·`b` + `r` and `r` < `b` for `b`!=0. No intermediate value exceeds 5 bits.

## Timing
- Start accepted at edge T (b≠0): `busy`=1 for cycles T+1..T+4; `done`=1 in cycle T+5 only; `busy`=0 in T+5.
- Start accepted at edge T (b=0): `busy` stays 0; `done`=1 in cycle T+1.
- Back-to-back: `start` held high through a DONE cycle begins the next operation. The `busy` of the new operation follows the `done` cycle with no idle gap, so throughput is one division per 5 cycles.
- Reset has priority over `start` in the same edge.
- `a`/`b` may change freely after the accept edge without affecting the result.

## Test plan
- Reset, then `a`=13, `b`=3, pulse `start` → `busy` for 4 cycles; at T+5 `done`=1, `q`=4, `r`=1, `dz`=0.
- `a`=15, `b`=1 → `q`=15, `r`=0. `a`=2, `b`=9 → `q`=0, `r`=2. `a`=0, `b`=5 → `q`=0, `r`=0.
- `a`=7, `b`=0 → `done` at T+1, `busy` never high, `q`=15, `r`=7, `dz`=1. A following 9/4 → `dz`=0, `q`=2, `r`=1.
- Start 12/5, then pulse `start` with 15/15 at T+2 → ignored; `done` at T+5 with `q`=2, `r`=2.
- Start 14/3, and hold `start` high with 9/2 applied during the DONE cycle → first `done` gives `q`=4, `r`=2; the second `done` comes 5 cycles later with `q`=4, `r`=1.
- Start 11/2, drive `rst_n`=0 at T+3 → all outputs are 0 next edge and no `done` follows. Exhaustive 16×16 sweep checks `a`=`q`·`b`+`r` against a model.
